// File: rtl/edge_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter_if
//   Bundles the request-side and grant-side signals of edge_event_arbiter.
//
//   Signals:
//     req_in      [N]    raw request levels (already synchronous to clk)
//     ack                consumer accepts the grant currently presented
//     ovf_clr            synchronous clear of overflow flags and drop_count
//     grant_valid        a grant is being presented
//     grant_id    [IDW]  granted channel, meaningful while grant_valid=1
//     pending     [N]    latched, not yet serviced events
//     overflow    [N]    sticky per-channel overflow flags
//     drop_count  [CW]   saturating count of overflow events
//
//   Modports:
//     master : the arbiter (drives grants and status)
//     slave  : the environment (drives requests, ack and ovf_clr)
// ---------------------------------------------------------------------------
interface edge_event_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int CW  = 8
);
  logic [N-1:0]   req_in;
  logic           ack;
  logic           ovf_clr;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;
  logic [CW-1:0]  drop_count;

  modport master (
    input  req_in, ack, ovf_clr,
    output grant_valid, grant_id, pending, overflow, drop_count
  );

  modport slave (
    output req_in, ack, ovf_clr,
    input  grant_valid, grant_id, pending, overflow, drop_count
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
//   Detects rising edges on N request lines, latches each as a pending event
//   and hands pending events one at a time, round-robin, to a single consumer
//   over a valid/ack handshake. A new edge on a channel whose event is still
//   pending is an overflow: it sets a sticky per-channel flag and bumps a
//   saturating drop counter.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset of all state
//     bus    edge_event_arbiter_if.master
//              in : req_in, ack, ovf_clr
//              out: grant_valid, grant_id, pending, overflow, drop_count
//
//   Timing (idle arbiter): edge sampled at clock k -> pending after clock k,
//   grant_valid after clock k+1. After every accepted grant the FSM returns
//   to IDLE, so grant_valid is low for at least one cycle between grants.
// ---------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int CW  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  edge_event_arbiter_if.master bus
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("edge_event_arbiter: N must be in 2..8");
  end
  if (IDW != $clog2(N)) begin : g_bad_idw
    $error("edge_event_arbiter: IDW must equal clog2(N)");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   req_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overflow_q, overflow_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;

  logic [N-1:0]   edge_det;
  logic [N-1:0]   clr;
  logic [N-1:0]   ovf_evt;
  logic [IDW:0]   pick;

  // Number of set bits; N <= 8 fits in 4 bits.
  function automatic logic [3:0] popcount(input logic [N-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + 4'(v[i]);
    end
    return cnt;
  endfunction

  // a + b, clamped to the all-ones value of a CW-bit counter.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [3:0]    b);
    logic [CW+3:0] sum;
    logic [CW+3:0] lim;
    sum = (CW+4)'(a) + (CW+4)'(b);
    lim = (CW+4)'({CW{1'b1}});
    if (sum > lim) begin
      return {CW{1'b1}};
    end
    return sum[CW-1:0];
  endfunction

  // First set bit of pend scanning upward from ptr, wrapping mod N.
  // Returns {found, index}. The doubled vector shifted by ptr puts the
  // highest-priority channel at bit 0; scanning offsets downward lets the
  // lowest offset be the last (winning) assignment.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0]   pend,
                                           input logic [IDW-1:0] ptr);
    logic [2*N-1:0] rot;
    logic [IDW:0]   r;
    int             c;
    rot = {pend, pend} >> ptr;
    r   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        c = int'(ptr) + k;
        if (c >= N) c = c - N;
        r = {1'b1, IDW'(c)};
      end
    end
    return r;
  endfunction

  // (id + 1) mod N, for N not necessarily a power of two.
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    logic [IDW:0] nxt;
    nxt = (IDW+1)'(id) + (IDW+1)'(1);
    if (nxt >= (IDW+1)'(N)) begin
      return '0;
    end
    return nxt[IDW-1:0];
  endfunction

  assign pick = rr_pick(pending_q, rr_ptr_q);

  // Grant FSM: IDLE picks from the registered pending vector, GRANT holds
  // the choice until ack, then clears that channel and advances the pointer.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    clr        = '0;
    unique case (state_q)
      IDLE: begin
        if (pick[IDW]) begin
          grant_id_d = pick[IDW-1:0];
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          clr[grant_id_q] = 1'b1;
          rr_ptr_d        = next_ptr(grant_id_q);
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Event bookkeeping. A set and a clear in the same cycle leave the bit
  // set, and that case is not an overflow: the old event was just serviced.
  always_comb begin
    edge_det   = bus.req_in & ~req_q;
    ovf_evt    = edge_det & pending_q & ~clr;
    pending_d  = (pending_q & ~clr) | edge_det;
    overflow_d = (bus.ovf_clr ? '0 : overflow_q) | ovf_evt;
    drop_d     = sat_add(bus.ovf_clr ? '0 : drop_q, popcount(ovf_evt));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      drop_q     <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= bus.req_in;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.grant_valid = (state_q == GRANT);
  assign bus.grant_id    = grant_id_q;
  assign bus.pending     = pending_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter
//   Self-checking bench for edge_event_arbiter (N=4, IDW=2, CW=8):
//   a vector table, hand-written corner sequences and a randomized run
//   compared against an event-level reference model.
// ---------------------------------------------------------------------------
module tb_edge_event_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int CW   = 8;
  localparam int DMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;

  edge_event_arbiter_if #(.N(N), .IDW(IDW), .CW(CW)) bus ();

  edge_event_arbiter #(.N(N), .IDW(IDW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]   req;
    logic           ack;
    logic           clr;
    logic           gv;
    logic [IDW-1:0] gid;
    logic [N-1:0]   pend;
    logic [N-1:0]   ovf;
    logic [CW-1:0]  drop;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [N-1:0] r, logic a, logic c, logic gv,
                              logic [IDW-1:0] gid, logic [N-1:0] p,
                              logic [N-1:0] o, logic [CW-1:0] d);
    vec_t v;
    v.req = r; v.ack = a; v.clr = c; v.gv = gv;
    v.gid = gid; v.pend = p; v.ovf = o; v.drop = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic a, input logic c);
    bus.req_in  = r;
    bus.ack     = a;
    bus.ovf_clr = c;
  endtask

  task automatic check_outs(input string tag, input logic gv,
                            input logic [IDW-1:0] gid, input logic [N-1:0] pend,
                            input logic [N-1:0] ovf, input logic [CW-1:0] drop);
    checks++;
    if (bus.grant_valid !== gv) begin
      errors++;
      $display("FAIL %s grant_valid: got %b expected %b", tag, bus.grant_valid, gv);
    end
    checks++;
    if (bus.pending !== pend) begin
      errors++;
      $display("FAIL %s pending: got %b expected %b", tag, bus.pending, pend);
    end
    checks++;
    if (bus.overflow !== ovf) begin
      errors++;
      $display("FAIL %s overflow: got %b expected %b", tag, bus.overflow, ovf);
    end
    checks++;
    if (bus.drop_count !== drop) begin
      errors++;
      $display("FAIL %s drop_count: got %0d expected %0d", tag, bus.drop_count, drop);
    end
    if (gv === 1'b1) begin
      checks++;
      if (bus.grant_id !== gid) begin
        errors++;
        $display("FAIL %s grant_id: got %0d expected %0d", tag, bus.grant_id, gid);
      end
    end
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    reset = 1'b1;
    drive(r, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- event-level reference model ----------------
  bit m_prev[N];
  bit m_pend[N];
  bit m_ovf[N];
  int m_drop;
  bit m_busy;
  int m_gid;
  int m_start;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
    end
    m_drop = 0; m_busy = 0; m_gid = 0; m_start = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic a, input logic c);
    bit np[N];
    bit newovf[N];
    int nov;
    bit accept;
    nov = 0;
    accept = m_busy && a;
    for (int i = 0; i < N; i++) begin
      bit rise;
      bit served;
      rise   = r[i] && !m_prev[i];
      served = accept && (m_gid == i);
      np[i]  = m_pend[i];
      if (served) np[i] = 0;
      if (rise) np[i] = 1;
      newovf[i] = rise && m_pend[i] && !served;
      if (newovf[i]) nov++;
    end
    if (c) begin
      for (int i = 0; i < N; i++) m_ovf[i] = 0;
      m_drop = 0;
    end
    for (int i = 0; i < N; i++) if (newovf[i]) m_ovf[i] = 1;
    m_drop = (m_drop + nov > DMAX) ? DMAX : m_drop + nov;
    if (m_busy) begin
      if (a) begin
        m_busy  = 0;
        m_start = (m_gid + 1) % N;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int ch;
        ch = (m_start + k) % N;
        if (m_pend[ch]) begin
          m_gid  = ch;
          m_busy = 1;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      m_pend[i] = np[i];
      m_prev[i] = r[i];
    end
  endtask

  task automatic model_compare(input string tag);
    logic [N-1:0] p;
    logic [N-1:0] o;
    for (int i = 0; i < N; i++) begin
      p[i] = m_pend[i];
      o[i] = m_ovf[i];
    end
    check_outs(tag, m_busy, IDW'(m_gid), p, o, CW'(m_drop));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    logic a;
    logic c;

    // ---------------- vector table ----------------
    vq.push_back(mk(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000, 8'd0));
    vq.push_back(mk(4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 8'd0));
    vq.push_back(mk(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0));
    vq.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0));
    // all four rise with ack held high; pointer now starts at 1
    vq.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111, 4'b0000, 8'd0));
    vq.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1111, 4'b0000, 8'd0));
    vq.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1101, 4'b0000, 8'd0));
    vq.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1101, 4'b0000, 8'd0));
    vq.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1001, 4'b0000, 8'd0));
    vq.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1001, 4'b0000, 8'd0));
    vq.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000, 8'd0));
    vq.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 8'd0));
    vq.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0));
    // overflow on channel 2 while its grant is withheld, then clear
    vq.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0));
    vq.push_back(mk(4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000, 8'd0));
    vq.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 8'd0));
    vq.push_back(mk(4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0100, 8'd1));
    vq.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0100, 8'd1));
    vq.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0000, 8'd0));
    // new edge on the granted channel in the ack cycle: set wins, no overflow
    vq.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000, 8'd0));
    vq.push_back(mk(4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 8'd0));
    vq.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0));

    do_reset(4'b0001);
    check_outs("reset", 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].req, vq[i].ack, vq[i].clr);
      tick();
      check_outs($sformatf("vec%0d", i), vq[i].gv, vq[i].gid, vq[i].pend,
                 vq[i].ovf, vq[i].drop);
    end

    // ---------------- re-grant order after set-wins ----------------
    do_reset(4'b0000);
    drive(4'b0011, 1'b0, 1'b0); tick();
    check_outs("rr_a", 1'b0, 2'd0, 4'b0011, 4'b0000, 8'd0);
    drive(4'b0010, 1'b0, 1'b0); tick();
    check_outs("rr_b", 1'b1, 2'd0, 4'b0011, 4'b0000, 8'd0);
    drive(4'b0011, 1'b1, 1'b0); tick();
    check_outs("rr_c", 1'b0, 2'd0, 4'b0011, 4'b0000, 8'd0);
    drive(4'b0011, 1'b0, 1'b0); tick();
    check_outs("rr_d", 1'b1, 2'd1, 4'b0011, 4'b0000, 8'd0);
    drive(4'b0011, 1'b1, 1'b0); tick();
    check_outs("rr_e", 1'b0, 2'd0, 4'b0001, 4'b0000, 8'd0);
    drive(4'b0011, 1'b0, 1'b0); tick();
    check_outs("rr_f", 1'b1, 2'd0, 4'b0001, 4'b0000, 8'd0);

    // ---------------- drop counter saturation ----------------
    do_reset(4'b0000);
    drive(4'b0010, 1'b0, 1'b0); tick();
    for (int n = 1; n <= 260; n++) begin
      drive(4'b0000, 1'b0, 1'b0); tick();
      drive(4'b0010, 1'b0, 1'b0); tick();
      if (n == 100) check_outs("sat_100", 1'b1, 2'd1, 4'b0010, 4'b0010, 8'd100);
    end
    check_outs("sat_260", 1'b1, 2'd1, 4'b0010, 4'b0010, 8'd255);
    drive(4'b0000, 1'b0, 1'b0); tick();
    drive(4'b0010, 1'b0, 1'b1); tick();
    check_outs("clr_vs_new", 1'b1, 2'd1, 4'b0010, 4'b0010, 8'd1);

    // ---------------- asynchronous reset mid-grant ----------------
    do_reset(4'b0000);
    drive(4'b1010, 1'b0, 1'b0); tick();
    tick();
    drive(4'b1000, 1'b0, 1'b0); tick();
    drive(4'b1010, 1'b0, 1'b0); tick();
    check_outs("pre_areset", 1'b1, 2'd1, 4'b1010, 4'b0010, 8'd1);
    #2 reset = 1'b1;
    #1 check_outs("areset", 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0);
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_outs($sformatf("post_areset%0d", i), 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0);
    end

    // ---------------- randomized run against the model ----------------
    do_reset(4'b0000);
    model_reset();
    r = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) r[i] = ~r[i];
      end
      a = 1'($urandom_range(1));
      c = ($urandom_range(31) == 0);
      drive(r, a, c);
      model_step(r, a, c);
      tick();
      model_compare($sformatf("rand%0d", cyc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
